// File: rtl/decode_stage.sv
// decode_stage: IF/ID register, 32x32 register file with write-through bypass,
// field/immediate/jump decode and load-use hazard detection.
module decode_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr_if,
    input  logic [31:0] pc4_if,
    input  logic        flush,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ex_mem_rd,
    input  logic [4:0]  ex_rd,
    output logic        stall,
    output logic        id_valid,
    output logic [31:0] id_pc4,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [5:0]  id_funct,
    output logic [31:0] id_imm,
    output logic [31:0] id_jump,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        id_mem_rd
);
    logic [31:0] ir;
    logic [31:0] pc4;
    logic        v;
    logic [31:0] regs [32];
    logic        zext;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ir  <= '0;
            pc4 <= '0;
            v   <= 1'b0;
        end else if (flush) begin
            ir  <= '0;
            pc4 <= '0;
            v   <= 1'b0;
        end else if (!stall) begin
            ir  <= instr_if;
            pc4 <= pc4_if;
            v   <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_we && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign id_opcode = ir[31:26];
    assign id_rs     = ir[25:21];
    assign id_rt     = ir[20:16];
    assign id_rd     = ir[15:11];
    assign id_funct  = ir[5:0];
    assign id_pc4    = pc4;
    assign id_mem_rd = id_opcode == 6'h23;
    assign id_jump   = {pc4[31:28], ir[25:0], 2'b00};

    // ANDI/ORI/XORI take a zero-extended immediate, everything else sign-extends
    assign zext   = id_opcode == 6'h0C || id_opcode == 6'h0D || id_opcode == 6'h0E;
    assign id_imm = zext ? {16'h0000, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};

    // A matching nonzero write-back address implies the bypass must win over the array
    assign rs_data = id_rs == 5'd0 ? 32'd0 : (wb_we && wb_addr == id_rs) ? wb_data : regs[id_rs];
    assign rt_data = id_rt == 5'd0 ? 32'd0 : (wb_we && wb_addr == id_rt) ? wb_data : regs[id_rt];

    assign stall    = v & ex_mem_rd & (ex_rd != 5'd0) & ((ex_rd == id_rs) | (ex_rd == id_rt));
    assign id_valid = v & ~stall;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// behavioural model of the IF/ID register, register file and hazard rule.
module tb_decode_stage;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_if = '0;
    logic [31:0] pc4_if = '0;
    logic        flush = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        ex_mem_rd = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        stall, id_valid, id_mem_rd;
    logic [31:0] id_pc4, id_imm, id_jump, rs_data, rt_data;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;

    int passed = 0;
    int total = 0;

    logic [31:0] m_ir, m_pc4;
    logic        m_v;
    logic [31:0] m_rf [32];

    decode_stage dut (
        .clock(clock), .reset(reset), .instr_if(instr_if), .pc4_if(pc4_if),
        .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_mem_rd(ex_mem_rd), .ex_rd(ex_rd), .stall(stall), .id_valid(id_valid),
        .id_pc4(id_pc4), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_funct(id_funct), .id_imm(id_imm), .id_jump(id_jump),
        .rs_data(rs_data), .rt_data(rt_data), .id_mem_rd(id_mem_rd)
    );

    always #5 clock = ~clock;

    function automatic logic m_stall();
        return m_v && ex_mem_rd && ex_rd != 0 && (ex_rd == m_ir[25:21] || ex_rd == m_ir[20:16]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (wb_we && wb_addr == a) return wb_data;
        return m_rf[a];
    endfunction

    function automatic logic [31:0] m_imm();
        int op;
        op = int'(m_ir[31:26]);
        if (op >= 12 && op <= 14) return m_ir & 32'h0000FFFF;
        return 32'($signed(m_ir[15:0]));
    endfunction

    task automatic m_clear();
        m_ir = 0;
        m_pc4 = 0;
        m_v = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
    endtask

    task automatic step();
        logic [31:0] n_ir, n_pc4, wd;
        logic        n_v, we;
        logic [4:0]  wa;
        n_ir = m_ir;
        n_pc4 = m_pc4;
        n_v = m_v;
        if (flush) begin
            n_ir = 0;
            n_pc4 = 0;
            n_v = 0;
        end else if (!m_stall()) begin
            n_ir = instr_if;
            n_pc4 = pc4_if;
            n_v = 1;
        end
        we = wb_we;
        wa = wb_addr;
        wd = wb_data;
        @(posedge clock);
        #1;
        m_ir = n_ir;
        m_pc4 = n_pc4;
        m_v = n_v;
        if (we && wa != 0) m_rf[wa] = wd;
    endtask

    task automatic zero_inputs();
        instr_if = 0; pc4_if = 0; flush = 0; wb_we = 0;
        wb_addr = 0; wb_data = 0; ex_mem_rd = 0; ex_rd = 0;
    endtask

    task automatic test_reset();
        for (int p = 0; p < 2; p++) begin
            if (p == 1) begin
                for (int i = 1; i < 32; i++) begin
                    wb_we = 1; wb_addr = 5'(i); wb_data = $urandom;
                    instr_if = $urandom; pc4_if = $urandom;
                    step();
                end
            end
            reset = 0;
            m_clear();
            instr_if = $urandom; pc4_if = $urandom; flush = 1'($urandom);
            wb_we = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom;
            ex_mem_rd = 1'($urandom); ex_rd = 5'($urandom);
            #2;
            total++; if (id_valid !== 1'b0) $display("FAIL rst_valid p%0d got %b exp 0", p, id_valid); else passed++;
            total++; if (stall !== 1'b0) $display("FAIL rst_stall p%0d got %b exp 0", p, stall); else passed++;
            total++; if (rs_data !== 32'd0) $display("FAIL rst_rs p%0d got %h exp 0", p, rs_data); else passed++;
            total++; if (rt_data !== 32'd0) $display("FAIL rst_rt p%0d got %h exp 0", p, rt_data); else passed++;
            total++; if ({id_pc4, id_imm, id_opcode, id_rd, id_funct} !== '0)
                $display("FAIL rst_fields p%0d got pc4=%h imm=%h op=%h exp 0", p, id_pc4, id_imm, id_opcode); else passed++;
            #1;
            reset = 1;
            zero_inputs();
        end
        for (int i = 0; i < 32; i++) begin
            instr_if = {6'd0, 5'(i), 5'(31 - i), 16'd0};
            step();
            total++; if (rs_data !== 32'd0) $display("FAIL rst_read_rs r%0d got %h exp 0", i, rs_data); else passed++;
            total++; if (rt_data !== 32'd0) $display("FAIL rst_read_rt r%0d got %h exp 0", 31 - i, rt_data); else passed++;
        end
    endtask

    task automatic test_capture();
        instr_if = 32'h8C430004; pc4_if = 32'h00000010;
        step();
        total++; if (id_opcode !== 6'h23) $display("FAIL cap_opcode got %h exp 23", id_opcode); else passed++;
        total++; if (id_rs !== 5'd2 || id_rt !== 5'd3) $display("FAIL cap_regs got rs=%0d rt=%0d exp 2 3", id_rs, id_rt); else passed++;
        total++; if (id_imm !== 32'h4) $display("FAIL cap_imm got %h exp 00000004", id_imm); else passed++;
        total++; if (id_mem_rd !== 1'b1) $display("FAIL cap_mem_rd got %b exp 1", id_mem_rd); else passed++;
        total++; if (id_pc4 !== 32'h10) $display("FAIL cap_pc4 got %h exp 00000010", id_pc4); else passed++;
        total++; if (id_valid !== 1'b1) $display("FAIL cap_valid got %b exp 1", id_valid); else passed++;
    endtask

    task automatic test_imm_jump();
        instr_if = 32'h3421FFFF;
        step();
        total++; if (id_imm !== 32'h0000FFFF) $display("FAIL imm_ori got %h exp 0000ffff", id_imm); else passed++;
        total++; if (id_mem_rd !== 1'b0) $display("FAIL imm_ori_mem_rd got %b exp 0", id_mem_rd); else passed++;
        instr_if = 32'h2021FFFF;
        step();
        total++; if (id_imm !== 32'hFFFFFFFF) $display("FAIL imm_addi got %h exp ffffffff", id_imm); else passed++;
        instr_if = 32'h08000010; pc4_if = 32'h40000004;
        step();
        total++; if (id_jump !== 32'h40000040) $display("FAIL jump got %h exp 40000040", id_jump); else passed++;
    endtask

    task automatic test_regfile();
        instr_if = 32'h00A00020; pc4_if = 32'h20;
        step();
        wb_we = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
        #1;
        total++; if (rs_data !== 32'hDEADBEEF) $display("FAIL rf_bypass got %h exp deadbeef", rs_data); else passed++;
        step();
        wb_we = 0; wb_data = 0;
        #1;
        total++; if (rs_data !== 32'hDEADBEEF) $display("FAIL rf_persist got %h exp deadbeef", rs_data); else passed++;
        instr_if = 32'h00000000;
        step();
        wb_we = 1; wb_addr = 0; wb_data = 32'h1234;
        #1;
        total++; if (rs_data !== 32'd0) $display("FAIL rf_r0_bypass got %h exp 0", rs_data); else passed++;
        step();
        wb_we = 0;
        #1;
        total++; if (rs_data !== 32'd0 || rt_data !== 32'd0) $display("FAIL rf_r0_write got rs=%h rt=%h exp 0", rs_data, rt_data); else passed++;
    endtask

    task automatic test_load_use();
        instr_if = 32'h00612020; pc4_if = 32'h100;
        step();
        instr_if = 32'hFFFFFFFF; pc4_if = 32'h200; ex_mem_rd = 1; ex_rd = 3;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL lu_stall got %b exp 1", stall); else passed++;
        total++; if (id_valid !== 1'b0) $display("FAIL lu_valid got %b exp 0", id_valid); else passed++;
        step();
        total++; if ({id_opcode, id_rs, id_rt, id_rd, id_funct} !== {6'd0, 5'd3, 5'd1, 5'd4, 6'h20} || id_pc4 !== 32'h100)
            $display("FAIL lu_hold got op=%h rs=%0d rt=%0d rd=%0d fn=%h pc4=%h exp 0 3 1 4 20 100",
                     id_opcode, id_rs, id_rt, id_rd, id_funct, id_pc4); else passed++;
        total++; if (stall !== 1'b1) $display("FAIL lu_stall_held got %b exp 1", stall); else passed++;
        ex_rd = 1;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL lu_rt_match got %b exp 1", stall); else passed++;
        ex_rd = 0;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL lu_rd0 got %b exp 0", stall); else passed++;
        ex_rd = 3; ex_mem_rd = 0;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL lu_noload got %b exp 0", stall); else passed++;
    endtask

    task automatic test_flush_stall();
        ex_mem_rd = 1; ex_rd = 3; flush = 1;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL fs_stall_pre got %b exp 1", stall); else passed++;
        step();
        total++; if (id_valid !== 1'b0 || stall !== 1'b0) $display("FAIL fs_after got valid=%b stall=%b exp 0 0", id_valid, stall); else passed++;
        total++; if ({id_opcode, id_rs, id_rt, id_rd, id_funct} !== '0 || id_pc4 !== 32'd0)
            $display("FAIL fs_squash got op=%h rs=%0d rt=%0d pc4=%h exp 0", id_opcode, id_rs, id_rt, id_pc4); else passed++;
        zero_inputs();
    endtask

    task automatic test_random();
        logic [5:0]  ops [8];
        logic [31:0] e;
        ops = '{6'h00, 6'h23, 6'h0C, 6'h0D, 6'h0E, 6'h08, 6'h02, 6'h2B};
        for (int c = 0; c < 300; c++) begin
            instr_if = {ops[$urandom_range(7)], 5'($urandom_range(7)), 5'($urandom_range(7)), 16'($urandom)};
            pc4_if = $urandom;
            flush = $urandom_range(9) == 0;
            wb_we = 1'($urandom); wb_addr = 5'($urandom_range(7)); wb_data = $urandom;
            ex_mem_rd = 1'($urandom); ex_rd = 5'($urandom_range(7));
            #1;
            total++; if (stall !== m_stall()) $display("FAIL rnd_stall c%0d got %b exp %b", c, stall, m_stall()); else passed++;
            total++; if (id_valid !== (m_v && !m_stall())) $display("FAIL rnd_valid c%0d got %b exp %b", c, id_valid, m_v && !m_stall()); else passed++;
            total++; if (id_pc4 !== m_pc4) $display("FAIL rnd_pc4 c%0d got %h exp %h", c, id_pc4, m_pc4); else passed++;
            total++; if ({id_opcode, id_rs, id_rt, id_rd, id_funct} !== {m_ir[31:11], m_ir[5:0]})
                $display("FAIL rnd_fields c%0d got %h exp %h", c, {id_opcode, id_rs, id_rt, id_rd, id_funct}, {m_ir[31:11], m_ir[5:0]}); else passed++;
            e = m_imm();
            total++; if (id_imm !== e) $display("FAIL rnd_imm c%0d got %h exp %h", c, id_imm, e); else passed++;
            e = {m_pc4[31:28], m_ir[25:0], 2'b00};
            total++; if (id_jump !== e) $display("FAIL rnd_jump c%0d got %h exp %h", c, id_jump, e); else passed++;
            total++; if (id_mem_rd !== (m_ir[31:26] == 6'h23)) $display("FAIL rnd_mem_rd c%0d got %b", c, id_mem_rd); else passed++;
            e = m_read(m_ir[25:21]);
            total++; if (rs_data !== e) $display("FAIL rnd_rs c%0d got %h exp %h", c, rs_data, e); else passed++;
            e = m_read(m_ir[20:16]);
            total++; if (rt_data !== e) $display("FAIL rnd_rt c%0d got %h exp %h", c, rt_data, e); else passed++;
            step();
        end
        zero_inputs();
    endtask

    initial begin
        m_clear();
        test_reset();
        test_capture();
        test_imm_jump();
        test_regfile();
        test_load_use();
        test_flush_stall();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
